prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/prog_loader_byte_timer.sv | 48 ++++
 rtl/prog_loader.sv | 140 ++++++++++++++
 tb/tb_prog_loader.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_LO,
    ST_HI,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [7:0]  SYNC_BYTE       = 8'hA5;
  localparam int unsigned TIMEOUT_DEFAULT = 1000;

  // States in which a frame is open and the inter-byte timer runs.
  function automatic logic in_frame(input state_e s);
    return (s == ST_COUNT) || (s == ST_LO) || (s == ST_HI) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/prog_loader_byte_timer.sv
// Reloadable inter-byte down-counter; expire_o pulses one cycle after TIMEOUT
// idle cycles, so the FSM can react on the TIMEOUT-th edge. TIMEOUT must be >= 2.
module byte_timer
  import prog_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int unsigned    CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (!run_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q == CNT_W'(1)) begin
      cnt_d    = '0;
      expire_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/prog_loader.sv
// Receives a SYNC/N/data/CHK frame over UART bytes and writes 16-bit words
// into program memory, holding the CPU while a load is in progress.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        lo_q, lo_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, done_q, err_q;
  logic              expire;

  byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run_i    (in_frame(state_d)),
    .load_i   (rx_valid),
    .expire_o (expire)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_d      = last_q;
    sum_d       = sum_q;
    lo_d        = lo_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (rx_valid) begin
          if ((rx_data == 8'd0) || (32'(rx_data) > DEPTH)) begin
            state_d = ST_ERR;
          end else begin
            // Keep N-1 so the last-word compare is a plain equality on the address.
            last_d  = ADDR_W'(rx_data - 8'd1);
            addr_d  = '0;
            sum_d   = '0;
            state_d = ST_LO;
          end
        end
      end
      ST_LO: begin
        if (rx_valid) begin
          lo_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (rx_valid) begin
          sum_d       = sum_q + rx_data;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = {rx_data, lo_q};
          if (addr_q == last_q) begin
            state_d = ST_CHK;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_LO;
          end
        end
      end
      ST_CHK: begin
        if (rx_valid) state_d = (rx_data == sum_q) ? ST_DONE : ST_ERR;
      end
      ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A byte on the expiry edge still counts as arriving in time.
    if (in_frame(state_q) && !rx_valid && expire) state_d = ST_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      last_q      <= '0;
      sum_q       <= '0;
      lo_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      sum_q       <= sum_d;
      lo_q        <= lo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      err_q       <= (state_d == ST_ERR);
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed vectors, timing sequences and
// random byte streams scored against a frame-level reference model.
module tb_prog_loader;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned TIMEOUT = 40;
  localparam int unsigned DEPTH   = 16;

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int                done_cnt;
  int                err_cnt;
  logic [ADDR_W-1:0] wr_addr [$];
  logic [15:0]       wr_data [$];
  logic [15:0]       mem_img [DEPTH];

  logic [7:0]        stim [$];
  logic [ADDR_W-1:0] exp_addr [$];
  logic [15:0]       exp_data [$];
  int                exp_done;
  int                exp_err;
  logic [15:0]       exp_mem [DEPTH];

  typedef struct {
    logic [63:0] bytes_le;   // byte j in bits [8j+7:8j], first byte lowest
    int          len;
    int          n_wr;
    logic [15:0] w0;
    logic [15:0] w1;
    int          n_done;
    int          n_err;
  } vec_t;

  vec_t vecs [6];

  // Output monitor: records every write and pulse just after each edge.
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      mem_img[mem_addr] = mem_wdata;
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the falling edge right after the byte was sampled.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input int max_gap);
    foreach (stim[k]) begin
      send(stim[k]);
      idle(int'($urandom_range(max_gap, 0)));
    end
  endtask

  // Frame-level model: walks the byte stream by the frame rules; a stream
  // that ends inside a frame is later closed by the inter-byte timeout.
  task automatic model_run();
    int         i;
    int         n;
    logic [7:0] lo, hi, sum;
    bit         ok;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 0;
    exp_err  = 0;
    i = 0;
    while (i < stim.size()) begin
      if (stim[i] != 8'hA5) begin
        i++;
        continue;
      end
      i++;
      if (i >= stim.size()) begin
        exp_err++;
        break;
      end
      n = int'(stim[i]);
      i++;
      if (n == 0 || n > int'(DEPTH)) begin
        exp_err++;
        continue;
      end
      sum = 8'h00;
      ok  = 1'b1;
      for (int w = 0; w < n; w++) begin
        if (i + 1 >= stim.size()) begin
          ok = 1'b0;
          break;
        end
        lo  = stim[i];
        hi  = stim[i+1];
        i  += 2;
        sum = sum + lo + hi;
        exp_addr.push_back(ADDR_W'(w));
        exp_data.push_back({hi, lo});
        exp_mem[w] = {hi, lo};
      end
      if (!ok || i >= stim.size()) begin
        exp_err++;
        break;
      end
      if (stim[i] == sum) exp_done++;
      else exp_err++;
      i++;
    end
  endtask

  task automatic compare_run(input string tag);
    check({tag, "_nwr"}, 32'(wr_data.size()), 32'(exp_data.size()));
    for (int k = 0; k < exp_data.size() && k < wr_data.size(); k++) begin
      check({tag, "_addr"}, 32'(wr_addr[k]), 32'(exp_addr[k]));
      check({tag, "_data"}, 32'(wr_data[k]), 32'(exp_data[k]));
    end
    check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
  endtask

  function automatic logic [15:0] word16(input int w);
    logic [7:0] lo, hi;
    lo = (w % 3 == 0) ? 8'hA5 : 8'(w * 7);
    hi = (w % 4 == 1) ? 8'hA5 : 8'(8'hF0 + w);
    return {hi, lo};
  endfunction

  function automatic logic [7:0] rnd_byte();
    if ($urandom_range(7, 0) == 0) return 8'hA5;
    return 8'($urandom_range(255, 0));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  sum;
    logic [15:0] w;
    int          n;
    int          c;

    vecs[0] = '{64'h0014_5678_1234_02A5, 7, 2, 16'h1234, 16'h5678, 1, 0};
    vecs[1] = '{64'h0000_0000_2211_01A5, 5, 1, 16'h2211, 16'h0000, 0, 1};
    vecs[2] = '{64'h0000_0000_0000_00A5, 2, 0, 16'h0000, 16'h0000, 0, 1};
    vecs[3] = '{64'h0000_0000_0000_11A5, 2, 0, 16'h0000, 16'h0000, 0, 1};
    vecs[4] = '{64'h0000_0000_005A_FF00, 3, 0, 16'h0000, 16'h0000, 0, 0};
    vecs[5] = '{64'h0000_0001_02FF_01A5, 5, 1, 16'h02FF, 16'h0000, 1, 0};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    idle(2);

    // Directed frame vectors
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      for (int j = 0; j < vecs[v].len; j++) send(vecs[v].bytes_le[8*j +: 8]);
      idle(4);
      check($sformatf("vec%0d_nwr", v), 32'(wr_data.size()), 32'(vecs[v].n_wr));
      if (vecs[v].n_wr > 0) begin
        check($sformatf("vec%0d_addr0", v), 32'(wr_addr[0]), 32'd0);
        check($sformatf("vec%0d_w0", v), 32'(wr_data[0]), 32'(vecs[v].w0));
      end
      if (vecs[v].n_wr > 1) begin
        check($sformatf("vec%0d_addr1", v), 32'(wr_addr[1]), 32'd1);
        check($sformatf("vec%0d_w1", v), 32'(wr_data[1]), 32'(vecs[v].w1));
      end
      check($sformatf("vec%0d_done", v), 32'(done_cnt), 32'(vecs[v].n_done));
      check($sformatf("vec%0d_err", v), 32'(err_cnt), 32'(vecs[v].n_err));
      check($sformatf("vec%0d_hold_idle", v), 32'(cpu_hold), 32'd0);
    end

    // Cycle-accurate write/done/hold timing
    clear_mon();
    check("seq_hold_before", 32'(cpu_hold), 32'd0);
    send(8'hA5);
    check("seq_hold_rise", 32'(cpu_hold), 32'd1);
    send(8'h02);
    send(8'h34);
    check("seq_no_we_lo", 32'(mem_we), 32'd0);
    send(8'h12);
    check("seq_we0", 32'(mem_we), 32'd1);
    check("seq_addr0", 32'(mem_addr), 32'd0);
    check("seq_data0", 32'(mem_wdata), 32'h1234);
    @(negedge clk);
    check("seq_we0_one_cycle", 32'(mem_we), 32'd0);
    send(8'h78);
    send(8'h56);
    check("seq_we1", 32'(mem_we), 32'd1);
    check("seq_addr1", 32'(mem_addr), 32'd1);
    check("seq_data1", 32'(mem_wdata), 32'h5678);
    send(8'h14);
    check("seq_done_pulse", 32'(done), 32'd1);
    check("seq_no_we_chk", 32'(mem_we), 32'd0);
    check("seq_hold_in_done", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    check("seq_done_one_cycle", 32'(done), 32'd0);
    check("seq_hold_fall", 32'(cpu_hold), 32'd0);
    check("seq_err_none", 32'(err_cnt), 32'd0);

    // Timeout: err exactly TIMEOUT cycles after the last byte
    clear_mon();
    send(8'hA5);
    send(8'h02);
    send(8'h34);
    c = 0;
    while (err !== 1'b1 && c < 2 * int'(TIMEOUT)) begin
      @(negedge clk);
      c++;
    end
    check("timeout_latency", 32'(c), 32'(TIMEOUT));
    check("timeout_hold_in_err", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    check("timeout_err_one_cycle", 32'(err), 32'd0);
    check("timeout_hold_fall", 32'(cpu_hold), 32'd0);
    check("timeout_err_cnt", 32'(err_cnt), 32'd1);
    check("timeout_no_write", 32'(wr_data.size()), 32'd0);

    // A byte arriving exactly TIMEOUT cycles after the previous one is accepted
    clear_mon();
    send(8'hA5);
    send(8'h01);
    send(8'h11);
    idle(int'(TIMEOUT) - 2);
    send(8'h22);
    send(8'h33);
    idle(4);
    check("gapmax_done", 32'(done_cnt), 32'd1);
    check("gapmax_err", 32'(err_cnt), 32'd0);
    check("gapmax_data", 32'(wr_data[0]), 32'h2211);

    // Reset mid-frame aborts silently; the next frame needs a fresh SYNC
    clear_mon();
    send(8'hA5);
    send(8'h02);
    send(8'h34);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("midrst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    idle(int'(TIMEOUT) + 5);
    check("midrst_no_err", 32'(err_cnt), 32'd0);
    send(8'h12);
    send(8'h34);
    check("midrst_idle_hold", 32'(cpu_hold), 32'd0);
    send(8'hA5);
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    send(8'h65);
    idle(3);
    check("midrst_next_done", 32'(done_cnt), 32'd1);
    check("midrst_next_data", 32'(wr_data[0]), 32'hBBAA);
    check("midrst_next_addr", 32'(wr_addr[0]), 32'd0);

    // Reset wins over a SYNC byte in the same cycle
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    check("rst_vs_sync_hold", 32'(cpu_hold), 32'd0);
    idle(2);
    check("rst_vs_sync_hold_later", 32'(cpu_hold), 32'd0);

    // Non-SYNC bytes in IDLE
    send(8'h00);
    check("idle_00_hold", 32'(cpu_hold), 32'd0);
    send(8'hFF);
    check("idle_FF_hold", 32'(cpu_hold), 32'd0);
    send(8'h5A);
    check("idle_5A_hold", 32'(cpu_hold), 32'd0);

    // Full-depth frame with A5 in the data
    stim.delete();
    stim.push_back(8'hA5);
    stim.push_back(8'd16);
    sum = 8'h00;
    for (int k = 0; k < 16; k++) begin
      w = word16(k);
      stim.push_back(w[7:0]);
      stim.push_back(w[15:8]);
      sum = sum + w[7:0] + w[15:8];
    end
    stim.push_back(sum);
    clear_mon();
    send_stream(0);
    idle(4);
    check("full_nwr", 32'(wr_data.size()), 32'd16);
    for (int k = 0; k < 16 && k < wr_data.size(); k++) begin
      check($sformatf("full_addr%0d", k), 32'(wr_addr[k]), 32'(k));
      check($sformatf("full_data%0d", k), 32'(wr_data[k]), 32'(word16(k)));
    end
    check("full_done", 32'(done_cnt), 32'd1);
    check("full_err", 32'(err_cnt), 32'd0);

    // Random streams against the reference model
    for (int a = 0; a < int'(DEPTH); a++) begin
      mem_img[a] = 16'hDEAD;
      exp_mem[a] = 16'hDEAD;
    end
    for (int f = 0; f < 25; f++) begin
      stim.delete();
      repeat ($urandom_range(2, 0)) stim.push_back(8'($urandom_range(255, 0)));
      stim.push_back(8'hA5);
      if ($urandom_range(7, 0) == 0)
        n = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, 17));
      else
        n = int'($urandom_range(16, 1));
      stim.push_back(8'(n));
      if (n >= 1 && n <= 16) begin
        sum = 8'h00;
        for (int k = 0; k < n; k++) begin
          stim.push_back(rnd_byte());
          stim.push_back(rnd_byte());
          sum = sum + stim[stim.size()-2] + stim[stim.size()-1];
        end
        if ($urandom_range(3, 0) == 0) sum = sum ^ 8'($urandom_range(255, 1));
        stim.push_back(sum);
        if ($urandom_range(7, 0) == 0)
          repeat ($urandom_range(3, 1)) void'(stim.pop_back());
      end
      model_run();
      clear_mon();
      send_stream(3);
      idle(int'(TIMEOUT) + 5);
      compare_run($sformatf("rand%0d", f));
    end
    for (int a = 0; a < int'(DEPTH); a++)
      check($sformatf("mem_img%0d", a), 32'(mem_img[a]), 32'(exp_mem[a]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
